// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, in-order imem requests,
// response buffer to decode, and flush/restart on redirect
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   fifo_instr [FIFO_DEPTH];

   logic [CW:0]   credit_used;
   logic [31:0]   redirect_target;
   logic          req_fire;
   logic          drop;
   logic          push;
   logic          pop;
   logic [CW-1:0] resp_dec;

   assign redirect_target = {redirect_pc[31:2], 2'b00};
   // Credit counts buffered entries plus in-flight requests; a same-cycle pop is not credited.
   assign credit_used     = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid  = !rst && !redirect_valid && (credit_used < DEPTH_W);
   assign imem_addr       = fetch_pc;

   assign if_valid = !rst && (count != '0) && !redirect_valid;
   assign if_instr = fifo_instr[rd_ptr];
   assign if_pc    = fifo_pc[rd_ptr];

   assign req_fire = imem_req_valid && imem_req_ready;
   assign drop     = imem_resp_valid && (drop_cnt != '0);
   assign push     = imem_resp_valid && (drop_cnt == '0);
   assign pop      = if_valid && if_ready;
   assign resp_dec = CW'(imem_resp_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc[i]    <= '0;
            fifo_instr[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_target;
         resp_pc     <= redirect_target;
         count       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= outstanding - resp_dec;
         // Every request still in flight after this cycle belongs to the abandoned path,
         // including ones already marked for dropping by an earlier redirect.
         drop_cnt    <= outstanding - resp_dec;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         outstanding <= outstanding + CW'(req_fire) - resp_dec;
         if (drop) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= imem_resp_data;
            wr_ptr             <= wr_ptr + AW'(1);
            resp_pc            <= resp_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a fixed-latency memory model
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 1;
   logic [31:0] exp_fetch = '0;
   logic [31:0] sb [$];
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic [31:0] pop_log [$];
   int n_acc, n_pop, first_acc_cyc, first_val_cyc;
   logic [31:0] first_acc_addr;
   logic rd_valid = 1'b0;
   logic [31:0] rd_pc = '0;
   logic mem_ready = 1'b1;
   logic dec_ready = 1'b1;
   logic junk_resp = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive inputs, settle, check/score the events of the coming edge, then advance.
   task automatic step();
      logic resp;
      logic [31:0] e;
      resp = !rst && mq_due.size() > 0 && mq_due[0] == cyc;
      imem_resp_valid = resp || (rst && junk_resp);
      imem_resp_data  = resp ? mem_word(mq_addr[0]) : $urandom;
      imem_req_ready  = mem_ready;
      if_ready        = dec_ready;
      redirect_valid  = rd_valid;
      redirect_pc     = rd_pc;
      #1;
      if (rst) begin
         check("rst_req_valid", 32'(imem_req_valid), 32'd0);
         check("rst_if_valid", 32'(if_valid), 32'd0);
      end else if (rd_valid) begin
         check("redir_if_valid", 32'(if_valid), 32'd0);
         check("redir_req_valid", 32'(imem_req_valid), 32'd0);
         sb.delete();
         pop_log.delete();
         exp_fetch = {rd_pc[31:2], 2'b00};
      end else begin
         if (imem_req_valid) begin
            check("imem_addr", imem_addr, exp_fetch);
            if (imem_req_ready) begin
               sb.push_back(exp_fetch);
               mq_addr.push_back(imem_addr);
               mq_due.push_back(cyc + lat);
               if (n_acc == 0) first_acc_addr = imem_addr;
               if (first_acc_cyc < 0) first_acc_cyc = cyc;
               exp_fetch += 32'd4;
               n_acc++;
            end
         end
         if (if_valid) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            if (if_ready) begin
               check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("if_pc", if_pc, e);
                  check("if_instr", if_instr, mem_word(e));
               end
               pop_log.push_back(if_pc);
               n_pop++;
            end
         end
      end
      if (resp) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; rd_valid = 1'b0; mem_ready = 1'b1; dec_ready = 1'b1;
      mq_addr.delete(); mq_due.delete(); sb.delete(); pop_log.delete();
      exp_fetch = 32'h0;
      junk_resp = 1'b1;
      step();
      step();
      junk_resp = 1'b0;
      rst = 1'b0;
      n_acc = 0; n_pop = 0; first_acc_cyc = -1; first_val_cyc = -1;
   endtask

   task automatic clear_counts();
      n_acc = 0; n_pop = 0; pop_log.delete();
   endtask

   initial begin
      bit hit;
      @(negedge clk);

      // Reset and streaming at L=1
      lat = 1;
      do_reset();
      imem_resp_valid = 1'b0;
      #1;
      check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      check("post_rst_addr", imem_addr, 32'h0);
      check("post_rst_if_valid", 32'(if_valid), 32'd0);
      check("post_rst_if_pc", if_pc, 32'h0);
      check("post_rst_if_instr", if_instr, 32'h0);
      repeat (20) step();
      check("first_out_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);
      check("stream_accepts", 32'(n_acc), 32'd20);
      check("stream_pops_gapfree", 32'(n_pop), 32'd18);

      // Decode stall right after reset
      do_reset();
      dec_ready = 1'b0;
      repeat (10) step();
      check("stall_accepts", 32'(n_acc), 32'd4);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_pops", 32'(n_pop), 32'd0);
      dec_ready = 1'b1;
      repeat (12) step();
      check("stall_release_pops", 32'(n_pop), 32'd12);
      check("stall_first_pc", pop_log[0], 32'h0);
      check("stall_fourth_pc", pop_log[3], 32'hC);

      // Redirect with two requests in flight at L=3
      lat = 3;
      do_reset();
      hit = 0;
      for (int i = 0; i < 10 && !hit; i++) begin
         if (mq_due.size() == 2) hit = 1;
         else step();
      end
      check("redir_two_inflight", 32'(hit), 32'd1);
      rd_valid = 1'b1; rd_pc = 32'h100;
      step();
      rd_valid = 1'b0;
      clear_counts();
      repeat (12) step();
      check("redir_pop_count_nz", 32'(n_pop != 0), 32'd1);
      if (n_pop != 0) check("redir_first_pc", pop_log[0], 32'h100);

      // Redirect coinciding with a response and a ready decode
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (mq_due.size() > 0 && mq_due[0] == cyc && if_valid) hit = 1;
         else step();
      end
      check("simul_reached", 32'(hit), 32'd1);
      rd_valid = 1'b1; rd_pc = 32'h207;
      clear_counts();
      step();
      rd_valid = 1'b0;
      check("simul_no_pop", 32'(n_pop), 32'd0);
      step();
      check("simul_one_accept", 32'(n_acc), 32'd1);
      check("simul_next_addr", first_acc_addr, 32'h204);
      repeat (10) step();
      if (n_pop != 0) check("simul_first_pc", pop_log[0], 32'h204);

      // Back-to-back redirects with requests in flight
      rd_valid = 1'b1; rd_pc = 32'h300;
      step();
      rd_pc = 32'h400;
      step();
      rd_valid = 1'b0;
      clear_counts();
      repeat (14) step();
      check("b2b_pop_count_nz", 32'(n_pop != 0), 32'd1);
      if (n_pop != 0) check("b2b_first_pc", pop_log[0], 32'h400);

      // Redirect while decode is stalled discards the buffer
      dec_ready = 1'b0;
      repeat (6) step();
      rd_valid = 1'b1; rd_pc = 32'h500;
      step();
      rd_valid = 1'b0; dec_ready = 1'b1;
      clear_counts();
      repeat (12) step();
      if (n_pop != 0) check("stall_redir_first_pc", pop_log[0], 32'h500);
      check("stall_redir_pops_nz", 32'(n_pop != 0), 32'd1);

      // Memory backpressure on request 0x10
      lat = 1;
      do_reset();
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         #1;
         if (imem_req_valid && imem_addr == 32'h10) hit = 1;
         else step();
      end
      check("bp_reached", 32'(hit), 32'd1);
      mem_ready = 1'b0;
      repeat (3) begin
         step();
         check("bp_hold_addr", imem_addr, 32'h10);
         check("bp_hold_valid", 32'(imem_req_valid), 32'd1);
      end
      mem_ready = 1'b1;
      clear_counts();
      step();
      check("bp_accept_once", first_acc_addr, 32'h10);
      repeat (12) step();
      check("bp_accepts", 32'(n_acc), 32'd13);

      // Address wrap past 2^32
      rd_valid = 1'b1; rd_pc = 32'hFFFF_FFF8;
      step();
      rd_valid = 1'b0;
      clear_counts();
      repeat (10) step();
      check("wrap_pop_count", 32'(n_pop >= 3), 32'd1);
      if (n_pop >= 3) begin
         check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
         check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
         check("wrap_pc2", pop_log[2], 32'h0000_0000);
      end

      // Reset in the middle of streaming
      rst = 1'b1;
      step();
      check("midrst_if_valid", 32'(if_valid), 32'd0);
      do_reset();
      #1;
      check("midrst_addr", imem_addr, 32'h0);
      check("midrst_if_pc", if_pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
